// File: rtl/issue_unit.sv
// Tomasulo issue stage: fetches one instruction per handshake, renames via RegStat, issues to a free RS slot.
// Latency: disponivel high in cycle t, issue pulse visible in cycle t+2 when a slot is free (max 1 instr / 3 cycles).
// Backpressure: stalls in ISSUE while no slot is free; optional ISSUE_STATS_EN adds saturating 16-bit counters.
module issue_unit #(
    parameter int ADD_RS = 3,
    parameter int MUL_RS = 2,
    parameter int TAGW   = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              enableIn,
    input  logic [15:0]       instructionIn,
    output logic              disponivel,
    input  logic [ADD_RS-1:0] add_busy,
    input  logic [MUL_RS-1:0] mul_busy,
    input  logic              cdb_valid,
    input  logic [TAGW-1:0]   cdb_tag,
    output logic              issue_add,
    output logic              issue_mul,
    output logic [2:0]        issue_slot,
    output logic [3:0]        issue_op,
    output logic [2:0]        issue_rd,
    output logic [2:0]        issue_rs,
    output logic [2:0]        issue_rt,
    output logic [TAGW-1:0]   issue_qj,
    output logic [TAGW-1:0]   issue_qk,
    output logic [TAGW-1:0]   issue_tag
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]       issued_count,
    output logic [15:0]       stall_cycles,
    output logic [15:0]       dropped_count
`endif
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0100;

    typedef enum logic [1:0] {REQ, WAIT, ISSUE} state_t;

    state_t            state;
    logic [12:0]       held;
    logic [TAGW-1:0]   reg_stat [8];
    logic [ADD_RS-1:0] add_mask;
    logic [MUL_RS-1:0] mul_mask;

    logic              unused_hi;
    assign unused_hi = ^instructionIn[15:13];

    logic [3:0] h_op;
    logic [2:0] h_rd, h_rs, h_rt;
    assign h_op = held[3:0];
    assign h_rt = held[6:4];
    assign h_rs = held[9:7];
    assign h_rd = held[12:10];

    logic is_add_op, is_mul_op;
    assign is_add_op = (h_op == OP_ADD) || (h_op == OP_SUB);
    assign is_mul_op = (h_op == OP_MUL);

    logic [ADD_RS-1:0] add_free, add_pick;
    logic [MUL_RS-1:0] mul_free, mul_pick;
    logic [2:0]        add_slot, mul_slot;
    logic              add_found, mul_found;

    assign add_free = ~add_busy & ~add_mask;
    assign mul_free = ~mul_busy & ~mul_mask;
    // Lowest-set-bit isolation gives the one-hot of the slot being issued.
    assign add_pick = add_free & (~add_free + ADD_RS'(1));
    assign mul_pick = mul_free & (~mul_free + MUL_RS'(1));
    assign add_found = |add_free;
    assign mul_found = |mul_free;

    always_comb begin
        add_slot = '0;
        for (int i = ADD_RS - 1; i >= 0; i--) begin
            if (add_free[i]) add_slot = 3'(i);
        end
        mul_slot = '0;
        for (int i = MUL_RS - 1; i >= 0; i--) begin
            if (mul_free[i]) mul_slot = 3'(i);
        end
    end

    logic            cdb_live;
    logic [TAGW-1:0] qj_raw, qk_raw, qj, qk, new_tag;
    logic            do_add, do_mul, do_issue, do_stall, do_drop;

    assign cdb_live = cdb_valid && (cdb_tag != '0);
    assign qj_raw   = reg_stat[h_rs];
    assign qk_raw   = reg_stat[h_rt];
    assign qj       = (cdb_live && cdb_tag == qj_raw) ? '0 : qj_raw;
    assign qk       = (cdb_live && cdb_tag == qk_raw) ? '0 : qk_raw;

    assign do_add   = (state == ISSUE) && is_add_op && add_found;
    assign do_mul   = (state == ISSUE) && is_mul_op && mul_found;
    assign do_issue = do_add || do_mul;
    assign do_drop  = (state == ISSUE) && !is_add_op && !is_mul_op;
    assign do_stall = (state == ISSUE) && !do_issue && !do_drop;
    assign new_tag  = do_add ? TAGW'(add_slot) + TAGW'(1)
                             : TAGW'(ADD_RS) + TAGW'(mul_slot) + TAGW'(1);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= REQ;
            disponivel <= 1'b0;
            held       <= '0;
            add_mask   <= '0;
            mul_mask   <= '0;
            issue_add  <= 1'b0;
            issue_mul  <= 1'b0;
            issue_slot <= '0;
            issue_op   <= '0;
            issue_rd   <= '0;
            issue_rs   <= '0;
            issue_rt   <= '0;
            issue_qj   <= '0;
            issue_qk   <= '0;
            issue_tag  <= '0;
            for (int i = 0; i < 8; i++) reg_stat[i] <= '0;
        end else begin
            disponivel <= 1'b0;
            add_mask   <= '0;
            mul_mask   <= '0;
            issue_add  <= 1'b0;
            issue_mul  <= 1'b0;
            issue_slot <= '0;
            issue_op   <= '0;
            issue_rd   <= '0;
            issue_rs   <= '0;
            issue_rt   <= '0;
            issue_qj   <= '0;
            issue_qk   <= '0;
            issue_tag  <= '0;

            case (state)
                REQ: begin
                    disponivel <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (enableIn) begin
                        held  <= instructionIn[12:0];
                        state <= ISSUE;
                    end else begin
                        state <= REQ;
                    end
                end
                ISSUE: begin
                    if (do_drop) begin
                        state <= REQ;
                    end else if (do_issue) begin
                        issue_add  <= do_add;
                        issue_mul  <= do_mul;
                        issue_slot <= do_add ? add_slot : mul_slot;
                        issue_op   <= h_op;
                        issue_rd   <= h_rd;
                        issue_rs   <= h_rs;
                        issue_rt   <= h_rt;
                        issue_qj   <= qj;
                        issue_qk   <= qk;
                        issue_tag  <= new_tag;
                        if (do_add) add_mask <= add_pick;
                        else        mul_mask <= mul_pick;
                        state      <= REQ;
                    end
                end
                default: state <= REQ;
            endcase

            // CDB clear first; a same-edge rename of rd wins.
            for (int i = 0; i < 8; i++) begin
                if (cdb_live && reg_stat[i] == cdb_tag) reg_stat[i] <= '0;
            end
            if (do_issue) reg_stat[h_rd] <= new_tag;
        end
    end

`ifdef ISSUE_STATS_EN
    always_ff @(posedge Clock) begin
        if (Reset) begin
            issued_count  <= '0;
            stall_cycles  <= '0;
            dropped_count <= '0;
        end else begin
            if (do_issue && issued_count != 16'hFFFF)  issued_count  <= issued_count + 16'd1;
            if (do_stall && stall_cycles != 16'hFFFF)  stall_cycles  <= stall_cycles + 16'd1;
            if (do_drop  && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: handshake timing, renaming, CDB forwarding, stalls, drops and reset abort.
module tb_issue_unit;
    logic        Clock = 1'b0;
    logic        Reset, enableIn, cdb_valid;
    logic [15:0] instructionIn;
    logic        disponivel, issue_add, issue_mul;
    logic [2:0]  add_busy, issue_slot, issue_rd, issue_rs, issue_rt;
    logic [1:0]  mul_busy;
    logic [2:0]  cdb_tag, issue_qj, issue_qk, issue_tag;
    logic [3:0]  issue_op;
`ifdef ISSUE_STATS_EN
    logic [15:0] issued_count, stall_cycles, dropped_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    issue_unit dut (
        .Clock(Clock), .Reset(Reset), .enableIn(enableIn), .instructionIn(instructionIn),
        .disponivel(disponivel), .add_busy(add_busy), .mul_busy(mul_busy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .issue_add(issue_add), .issue_mul(issue_mul), .issue_slot(issue_slot),
        .issue_op(issue_op), .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_tag(issue_tag)
`ifdef ISSUE_STATS_EN
        , .issued_count(issued_count), .stall_cycles(stall_cycles), .dropped_count(dropped_count)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (disponivel !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, disponivel, 1);
    endtask

    // Hands one instruction over; returns one sample into the ISSUE cycle.
    task automatic send(input string tag, input logic [15:0] instr);
        wait_req(tag);
        enableIn      = 1'b1;
        instructionIn = instr;
        step();
        enableIn      = 1'b0;
        check({tag, "_held_disp"}, disponivel, 0);
        check({tag, "_no_early"}, {issue_add, issue_mul}, 0);
    endtask

    task automatic expect_issue(input string tag, input logic add, input logic mul,
                                input logic [2:0] slot, input logic [3:0] op,
                                input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt,
                                input logic [2:0] qj, input logic [2:0] qk, input logic [2:0] t);
        check({tag, "_pulse"}, {issue_add, issue_mul}, {add, mul});
        check({tag, "_slot"}, issue_slot, slot);
        check({tag, "_tag"}, issue_tag, t);
        check({tag, "_qj"}, issue_qj, qj);
        check({tag, "_qk"}, issue_qk, qk);
        check({tag, "_op_rd_rs_rt"}, {issue_op, issue_rd, issue_rs, issue_rt}, {op, rd, rs, rt});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; enableIn = 1'b0; instructionIn = '0;
        add_busy = '0; mul_busy = '0; cdb_valid = 1'b0; cdb_tag = '0;
        repeat (3) step();
        check("rst_disp", disponivel, 0);
        check("rst_pulse", {issue_add, issue_mul}, 0);
        check("rst_fields", {issue_slot, issue_tag, issue_qj, issue_qk}, 0);
        Reset = 1'b0;

        // ADD R3,R1,R2
        send("add1", 16'h0CA0);
        step();
        expect_issue("add1", 1, 0, 0, 4'h0, 3, 1, 2, 0, 0, 1);
        add_busy = 3'b001;
        step();
        check("add1_one_cycle", issue_add, 0);

        // SUB R5,R3,R1 sees R3 renamed to tag 1
        send("sub", 16'h1591);
        step();
        expect_issue("sub", 1, 0, 1, 4'h1, 5, 3, 1, 1, 0, 2);
        add_busy = 3'b011;

        // MUL R6,R5,R4 stalls until mul slot 0 frees
        mul_busy = 2'b11;
        send("mul", 16'h1AC4);
        for (int i = 0; i < 3; i++) begin
            check("mul_stall_pulse", issue_mul, 0);
            check("mul_stall_disp", disponivel, 0);
            step();
        end
        mul_busy = 2'b10;
        step();
        expect_issue("mul", 0, 1, 0, 4'h4, 6, 5, 4, 2, 0, 4);
        mul_busy = 2'b01;
`ifdef ISSUE_STATS_EN
        check("stat_stall", stall_cycles, 3);
        check("stat_issued", issued_count, 3);
`endif

        // ADD R7,R5,R6 with CDB tag 2 broadcast in the issue cycle
        send("fwd", 16'h1EE0);
        cdb_valid = 1'b1; cdb_tag = 3'd2;
        step();
        cdb_valid = 1'b0; cdb_tag = 3'd0;
        expect_issue("fwd", 1, 0, 2, 4'h0, 7, 5, 6, 0, 4, 3);
        add_busy = 3'b111;

        // Unknown opcode is dropped
        send("bad", 16'h000F);
        step();
        check("bad_pulse", {issue_add, issue_mul}, 0);
        check("bad_disp_gap", disponivel, 0);
        step();
        check("bad_disp_next", disponivel, 1);
`ifdef ISSUE_STATS_EN
        check("stat_dropped", dropped_count, 1);
`endif

        // Queue empty during the request
        wait_req("idle");
        step();
        check("idle_gap", disponivel, 0);
        step();
        check("idle_reassert", disponivel, 1);

        // MUL R6,R6,R3: CDB clears tag 4 while this issue renames R6
        send("ovr", 16'h1B34);
        cdb_valid = 1'b1; cdb_tag = 3'd4;
        step();
        cdb_valid = 1'b0; cdb_tag = 3'd0;
        expect_issue("ovr", 0, 1, 1, 4'h4, 6, 6, 3, 0, 1, 5);

        // ADD R0,R6,R5: R6 keeps tag 5, R5 was cleared by the CDB
        add_busy = 3'b000;
        send("chk", 16'h0350);
        step();
        expect_issue("chk", 1, 0, 0, 4'h0, 0, 6, 5, 5, 0, 1);

        // Reset while holding ADD R2,R6,R3
        send("rst", 16'h0B30);
        Reset = 1'b1;
        step();
        check("rst_mid_pulse", {issue_add, issue_mul}, 0);
        check("rst_mid_disp", disponivel, 0);
        Reset = 1'b0;
`ifdef ISSUE_STATS_EN
        check("stat_rst", {issued_count, dropped_count}, 0);
`endif
        send("post", 16'h0730);
        step();
        expect_issue("post", 1, 0, 0, 4'h0, 1, 6, 3, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
